// File: rtl/parking_gate_ctrl_pkg.sv
// Shared types and constants for the parking gate controller: FSM state encoding,
// timer width and 7-segment patterns (active-low, bit order {g,f,e,d,c,b,a}).
package parking_gate_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_PWD = 3'd1,
    ST_GRANT    = 3'd2,
    ST_DENY     = 3'd3,
    ST_LOCKOUT  = 3'd4
  } state_e;

  localparam int TMR_W = 16;

  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/parking_gate_ctrl_seg7.sv
// Single-digit BCD to active-low 7-segment decoder; only built when PARK_SEVSEG_EN is
// defined, since nothing else instantiates it.
`ifdef PARK_SEVSEG_EN
module seg7_decoder
  import parking_gate_ctrl_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_BLANK;
    case (digit)
      4'd0: seg_n = 7'b1000000;
      4'd1: seg_n = 7'b1111001;
      4'd2: seg_n = 7'b0100100;
      4'd3: seg_n = 7'b0110000;
      4'd4: seg_n = 7'b0011001;
      4'd5: seg_n = 7'b0010010;
      4'd6: seg_n = 7'b0000010;
      4'd7: seg_n = 7'b1111000;
      4'd8: seg_n = 7'b0000000;
      4'd9: seg_n = 7'b0010000;
      default: seg_n = SEG_BLANK;
    endcase
  end

endmodule
`endif

// File: rtl/parking_gate_ctrl.sv
// Single-lane parking gate controller: sensor edge detect, password FSM with retry lockout,
// occupancy accounting. Optional PARK_SEVSEG_EN adds registered 7-seg digits of free spaces.
module parking_gate_ctrl
  import parking_gate_ctrl_pkg::*;
#(
  parameter int               CAPACITY     = 15,
  parameter int               CNT_W        = 8,
  parameter int               PWD_W        = 4,
  parameter logic [PWD_W-1:0] PASSWORD     = 4'h5,
  parameter int               MAX_TRIES    = 3,
  parameter int               PWD_TIMEOUT  = 64,
  parameter int               GREEN_CYCLES = 4,
  parameter int               LOCK_CYCLES  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sense_entry,
  input  logic             sense_exit,
  input  logic             pwd_valid,
  input  logic [PWD_W-1:0] pwd_in,
  output logic             green_light,
  output logic             red_light,
  output logic             lot_full,
  output logic             locked_out,
  output logic [CNT_W-1:0] space_used,
  output logic [CNT_W-1:0] space_available,
  output logic [15:0]      total_entries
`ifdef PARK_SEVSEG_EN
  ,
  output logic [6:0]       hex_tens,
  output logic [6:0]       hex_ones
`endif
);

  localparam logic [CNT_W-1:0] CAP_C       = CNT_W'(CAPACITY);
  localparam logic [2:0]       MAX_TRIES_C = 3'(MAX_TRIES);
  localparam logic [TMR_W-1:0] PWD_LIMIT   = TMR_W'(PWD_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] GREEN_LIMIT = TMR_W'(GREEN_CYCLES - 1);
  localparam logic [TMR_W-1:0] LOCK_LIMIT  = TMR_W'(LOCK_CYCLES - 1);

  logic             entry_cur_q, entry_prev_q, exit_cur_q, exit_prev_q;
  logic             entry_edge, exit_edge;
  state_e           state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [2:0]       tries_q, tries_d;
  logic             green_q, green_d, red_q, red_d;
  logic             locked_q, locked_d, full_q, full_d;
  logic [CNT_W-1:0] used_q, used_d, avail_q, avail_d;
  logic [15:0]      total_q, total_d;
  logic             grant_start;

  assign entry_edge = entry_cur_q & ~entry_prev_q;
  assign exit_edge  = exit_cur_q & ~exit_prev_q;

  // One timer serves the password timeout, green hold and lockout; every state change zeroes it.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q + 1'b1;
    tries_d = tries_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (entry_edge && !full_q) begin
          state_d = ST_WAIT_PWD;
          tries_d = '0;
        end
      end
      ST_WAIT_PWD: begin
        if (pwd_valid) begin
          timer_d = '0;
          if (pwd_in == PASSWORD) begin
            state_d = ST_GRANT;
          end else begin
            tries_d = tries_q + 1'b1;
            state_d = (tries_d == MAX_TRIES_C) ? ST_LOCKOUT : ST_DENY;
          end
        end else if (timer_q == PWD_LIMIT) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      ST_GRANT: begin
        if (timer_q == GREEN_LIMIT) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end
      end
      ST_DENY: begin
        state_d = ST_WAIT_PWD;
        timer_d = '0;
      end
      ST_LOCKOUT: begin
        if (timer_q == LOCK_LIMIT) begin
          state_d = ST_IDLE;
          timer_d = '0;
          tries_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  // A grant and an exit in the same cycle cancel; the count never leaves 0..CAPACITY.
  always_comb begin
    grant_start = (state_d == ST_GRANT) && (state_q != ST_GRANT);
    used_d      = used_q;
    if (grant_start && exit_edge) begin
      used_d = used_q;
    end else if (grant_start) begin
      if (used_q != CAP_C) used_d = used_q + 1'b1;
    end else if (exit_edge && (used_q != '0)) begin
      used_d = used_q - 1'b1;
    end
    total_d  = total_q + 16'(grant_start);
    avail_d  = CAP_C - used_d;
    full_d   = (used_d == CAP_C);
    green_d  = (state_d == ST_GRANT);
    red_d    = ~green_d;
    locked_d = (state_d == ST_LOCKOUT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entry_cur_q  <= 1'b0;
      entry_prev_q <= 1'b0;
      exit_cur_q   <= 1'b0;
      exit_prev_q  <= 1'b0;
      state_q      <= ST_IDLE;
      timer_q      <= '0;
      tries_q      <= '0;
      green_q      <= 1'b0;
      red_q        <= 1'b1;
      locked_q     <= 1'b0;
      full_q       <= 1'b0;
      used_q       <= '0;
      avail_q      <= CAP_C;
      total_q      <= '0;
    end else begin
      entry_cur_q  <= sense_entry;
      entry_prev_q <= entry_cur_q;
      exit_cur_q   <= sense_exit;
      exit_prev_q  <= exit_cur_q;
      state_q      <= state_d;
      timer_q      <= timer_d;
      tries_q      <= tries_d;
      green_q      <= green_d;
      red_q        <= red_d;
      locked_q     <= locked_d;
      full_q       <= full_d;
      used_q       <= used_d;
      avail_q      <= avail_d;
      total_q      <= total_d;
    end
  end

  assign green_light     = green_q;
  assign red_light       = red_q;
  assign lot_full        = full_q;
  assign locked_out      = locked_q;
  assign space_used      = used_q;
  assign space_available = avail_q;
  assign total_entries   = total_q;

`ifdef PARK_SEVSEG_EN
  // Decoding the reset value through the same path keeps the display flops reset to CAPACITY.
  logic [CNT_W-1:0] disp_val;
  logic [3:0]       tens_dig, ones_dig;
  logic [6:0]       seg_tens, seg_ones;
  logic [6:0]       hex_tens_q, hex_tens_d, hex_ones_q, hex_ones_d;

  always_comb begin
    disp_val   = rst ? CAP_C : avail_d;
    tens_dig   = 4'((int'(disp_val) / 10) % 10);
    ones_dig   = 4'(int'(disp_val) % 10);
    hex_tens_d = (int'(disp_val) > 99) ? SEG_DASH : seg_tens;
    hex_ones_d = (int'(disp_val) > 99) ? SEG_DASH : seg_ones;
  end

  seg7_decoder u_seg_tens (.digit(tens_dig), .seg_n(seg_tens));
  seg7_decoder u_seg_ones (.digit(ones_dig), .seg_n(seg_ones));

  always_ff @(posedge clk) begin
    hex_tens_q <= hex_tens_d;
    hex_ones_q <= hex_ones_d;
  end

  assign hex_tens = hex_tens_q;
  assign hex_ones = hex_ones_q;
`endif

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed scoreboard bench for parking_gate_ctrl with default parameters; 7-seg checks
// are compiled in when PARK_SEVSEG_EN is defined.
module tb_parking_gate_ctrl;

  logic        clk = 1'b0;
  logic        rst, sense_entry, sense_exit, pwd_valid;
  logic [3:0]  pwd_in;
  logic        green_light, red_light, lot_full, locked_out;
  logic [7:0]  space_used, space_available;
  logic [15:0] total_entries;
`ifdef PARK_SEVSEG_EN
  logic [6:0]  hex_tens, hex_ones;
`endif

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   exp_used   = 0;
  int   exp_tot    = 0;

  always #5 clk = ~clk;

  parking_gate_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .sense_entry     (sense_entry),
    .sense_exit      (sense_exit),
    .pwd_valid       (pwd_valid),
    .pwd_in          (pwd_in),
    .green_light     (green_light),
    .red_light       (red_light),
    .lot_full        (lot_full),
    .locked_out      (locked_out),
    .space_used      (space_used),
    .space_available (space_available),
    .total_entries   (total_entries)
`ifdef PARK_SEVSEG_EN
    ,
    .hex_tens        (hex_tens),
    .hex_ones        (hex_ones)
`endif
  );

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $error("FAIL sb_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        mismatched++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic status(input string tag, input logic g, input logic lk);
    push({tag, ".green"},  32'(g));
    push({tag, ".red"},    32'(!g));
    push({tag, ".locked"}, 32'(lk));
    push({tag, ".full"},   32'(exp_used == 15));
    push({tag, ".used"},   32'(exp_used));
    push({tag, ".avail"},  32'(15 - exp_used));
    push({tag, ".total"},  32'(exp_tot));
    pop_cmp(32'(green_light));
    pop_cmp(32'(red_light));
    pop_cmp(32'(locked_out));
    pop_cmp(32'(lot_full));
    pop_cmp(32'(space_used));
    pop_cmp(32'(space_available));
    pop_cmp(32'(total_entries));
  endtask

`ifdef PARK_SEVSEG_EN
  task automatic seg_check(input string tag, input logic [6:0] t, input logic [6:0] o);
    push({tag, ".hex_tens"}, 32'(t));
    push({tag, ".hex_ones"}, 32'(o));
    pop_cmp(32'(hex_tens));
    pop_cmp(32'(hex_ones));
  endtask
`endif

  task automatic entry_pulse();
    sense_entry = 1'b1;
    tick();
    sense_entry = 1'b0;
    tick();
  endtask

  task automatic exit_pulse();
    sense_exit = 1'b1;
    tick();
    sense_exit = 1'b0;
    tick();
    if (exp_used > 0) exp_used--;
  endtask

  task automatic send_pwd(input logic [3:0] v);
    pwd_valid = 1'b1;
    pwd_in    = v;
    tick();
    pwd_valid = 1'b0;
    pwd_in    = 4'h0;
  endtask

  task automatic grant_car(input string tag);
    entry_pulse();
    send_pwd(4'h5);
    if (exp_used < 15) exp_used++;
    exp_tot++;
    status(tag, 1'b1, 1'b0);
    repeat (4) tick();
  endtask

  initial begin
    rst = 1'b1; sense_entry = 1'b0; sense_exit = 1'b0; pwd_valid = 1'b0; pwd_in = 4'h0;
    tick();
    tick();
    status("reset", 1'b0, 1'b0);
`ifdef PARK_SEVSEG_EN
    seg_check("reset", 7'b1111001, 7'b0010010);
`endif
    rst = 1'b0;
    tick();

    // Exit with an empty lot must not underflow.
    exit_pulse();
    tick();
    status("exit_at_zero", 1'b0, 1'b0);

    // Correct password on the third cycle opens the gate for four cycles.
    entry_pulse();
    status("t1_wait", 1'b0, 1'b0);
    send_pwd(4'h5);
    exp_used = 1; exp_tot = 1;
    status("t1_grant", 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      tick();
      status("t1_green_hold", 1'b1, 1'b0);
    end
    tick();
    status("t1_green_end", 1'b0, 1'b0);

    // Three wrong attempts: two single-cycle denies, then a 32-cycle lockout.
    entry_pulse();
    send_pwd(4'h2);
    status("t2_deny1", 1'b0, 1'b0);
    tick();
    send_pwd(4'h2);
    status("t2_deny2", 1'b0, 1'b0);
    tick();
    send_pwd(4'h2);
    status("t2_lock_start", 1'b0, 1'b1);
    for (int i = 1; i < 32; i++) begin
      if (i == 4) send_pwd(4'h5);
      else tick();
      status("t2_lock_hold", 1'b0, 1'b1);
    end
    tick();
    status("t2_lock_end", 1'b0, 1'b0);
    entry_pulse();
    send_pwd(4'h2);
    status("t2_deny_after_lock", 1'b0, 1'b0);
    tick();
    send_pwd(4'h5);
    exp_used++; exp_tot++;
    status("t2_grant_after_lock", 1'b1, 1'b0);
    repeat (4) tick();

    // Fill the lot, then an arrival at full is ignored.
    for (int n = 0; n < 13; n++) begin
      grant_car("t3_fill");
`ifdef PARK_SEVSEG_EN
      if (exp_used == 3) seg_check("avail12", 7'b1111001, 7'b0100100);
`endif
    end
    status("t3_full", 1'b0, 1'b0);
    entry_pulse();
    send_pwd(4'h5);
    status("t3_entry_when_full", 1'b0, 1'b0);
    tick();

    // Down to five cars, then a grant and an exit land in the same cycle.
    for (int n = 0; n < 10; n++) exit_pulse();
    status("t4_after_exits", 1'b0, 1'b0);
    entry_pulse();
    sense_exit = 1'b1;
    tick();
    sense_exit = 1'b0;
    send_pwd(4'h5);
    exp_tot++;
    status("t4_grant_and_exit", 1'b1, 1'b0);
    repeat (4) tick();

    // Attempt on the 64th waiting cycle still counts; one cycle later the wait has aborted.
    entry_pulse();
    repeat (63) tick();
    send_pwd(4'h5);
    exp_used++; exp_tot++;
    status("t5_pwd_last_cycle", 1'b1, 1'b0);
    repeat (4) tick();
    entry_pulse();
    repeat (64) tick();
    send_pwd(4'h5);
    status("t5_timeout", 1'b0, 1'b0);

    // Reset in the middle of a grant.
    entry_pulse();
    send_pwd(4'h5);
    exp_used++; exp_tot++;
    status("t5_grant_before_rst", 1'b1, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_used = 0; exp_tot = 0;
    status("t5_rst_mid_grant", 1'b0, 1'b0);
    grant_car("t5_post_rst");

    compared++;
    assert (sb.size() == 0) else begin
      mismatched++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
